steer_quad_encoder: RTL and testbench

//  Multi-channel successor to joy2quad: converts digital left/right steering inputs into

---
 rtl/steer_quad_encoder_pkg.sv | 14 +
 rtl/steer_quad_encoder_if.sv | 23 ++
 rtl/steer_quad_encoder_channel.sv | 82 ++++++++
 rtl/steer_quad_encoder.sv | 48 ++++
 tb/tb_steer_quad_encoder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/steer_quad_encoder_pkg.sv
// steer_pkg: shared state type, reset phase and quadrature step helper
// for the steering quadrature encoder.
package steer_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN_R, ST_RUN_L} steer_state_t;

    localparam logic [1:0] PHASE_RESET = 2'b00;

    // {A,B}: right walks 00->10->11->01, left walks the reverse
    function automatic logic [1:0] gray_next(input logic [1:0] phase, input logic dir_right);
        return dir_right ? {~phase[0], phase[1]} : {phase[0], ~phase[1]};
    endfunction

endpackage

// File: rtl/steer_quad_encoder_if.sv
// steer_quad_encoder_if: rate window, steering requests and quadrature outputs.
interface steer_quad_encoder_if #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 16
);
    logic [DIV_W-1:0]      clkdiv_max;
    logic [DIV_W-1:0]      clkdiv_min;
    logic                  accel_en;
    logic [CHANNELS-1:0]   left;
    logic [CHANNELS-1:0]   right;
    logic [2*CHANNELS-1:0] steer;
    logic [CHANNELS-1:0]   step;

    modport master (
        output clkdiv_max, clkdiv_min, accel_en, left, right,
        input  steer, step
    );

    modport slave (
        input  clkdiv_max, clkdiv_min, accel_en, left, right,
        output steer, step
    );
endinterface

// File: rtl/steer_quad_encoder_channel.sv
// steer_quad_channel: one steering channel - input synchroniser, IDLE/RUN FSM,
// step-period divider with acceleration ramp, and quadrature phase register.
module steer_quad_channel
    import steer_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int ACCEL_SHIFT = 3
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [DIV_W-1:0] eff_max,
    input  logic [DIV_W-1:0] eff_min,
    input  logic             accel_en,
    input  logic             left,
    input  logic             right,
    output logic [1:0]       phase,
    output logic             step
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [1:0]       l_sync, r_sync;
    logic             cmd_r, cmd_l, load;
    steer_state_t     state, state_next;
    logic [DIV_W-1:0] period, cnt, dec, ramp, new_period;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            l_sync <= '0;
            r_sync <= '0;
        end else begin
            l_sync <= {l_sync[0], left};
            r_sync <= {r_sync[0], right};
        end
    end

    assign cmd_r = r_sync[1] & ~l_sync[1];
    assign cmd_l = l_sync[1] & ~r_sync[1];

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // The decoded command alone selects the next state from any state
    always_comb begin
        state_next = cmd_r ? ST_RUN_R : cmd_l ? ST_RUN_L : ST_IDLE;
    end

    always_comb begin
        step = cnt == '0 && ((state == ST_RUN_R && cmd_r) || (state == ST_RUN_L && cmd_l));
        load = state_next != ST_IDLE && state_next != state;
    end

    always_comb begin
        dec        = (period >> ACCEL_SHIFT) == '0 ? ONE : period >> ACCEL_SHIFT;
        ramp       = period - dec;
        new_period = !accel_en ? eff_max : (ramp < eff_min ? eff_min : ramp);
    end

    // Period follows the live window while idle, so it holds the clamped max
    // from the first cycle after reset onward
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            period <= ONE;
            cnt    <= '0;
            phase  <= PHASE_RESET;
        end else if (load) begin
            period <= eff_max;
            cnt    <= eff_max - ONE;
        end else if (step) begin
            period <= new_period;
            cnt    <= new_period - ONE;
            phase  <= gray_next(phase, state == ST_RUN_R);
        end else if (state_next == ST_IDLE) begin
            period <= eff_max;
        end else begin
            cnt    <= cnt - ONE;
        end
    end

endmodule

// File: rtl/steer_quad_encoder.sv
// steer_quad_encoder: multi-channel left/right to quadrature A/B converter with
// per-channel step acceleration and a shared runtime rate window.
module steer_quad_encoder
    import steer_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 16,
    parameter int ACCEL_SHIFT = 3
) (
    input logic           CLK,
    input logic           reset,
    steer_quad_encoder_if.slave bus
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0]      eff_max, eff_min, min_lo;
    logic [2*CHANNELS-1:0] steer_w;
    logic [CHANNELS-1:0]   step_w;

    // Zero periods are meaningless; min may never exceed max
    always_comb begin
        eff_max = bus.clkdiv_max == '0 ? ONE : bus.clkdiv_max;
        min_lo  = bus.clkdiv_min == '0 ? ONE : bus.clkdiv_min;
        eff_min = min_lo > eff_max ? eff_max : min_lo;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        steer_quad_channel #(
            .DIV_W       (DIV_W),
            .ACCEL_SHIFT (ACCEL_SHIFT)
        ) u_ch (
            .CLK      (CLK),
            .reset    (reset),
            .eff_max  (eff_max),
            .eff_min  (eff_min),
            .accel_en (bus.accel_en),
            .left     (bus.left[c]),
            .right    (bus.right[c]),
            .phase    (steer_w[2*c+:2]),
            .step     (step_w[c])
        );
    end

    assign bus.steer = steer_w;
    assign bus.step  = step_w;

endmodule

// File: tb/tb_steer_quad_encoder.sv
// tb_steer_quad_encoder: table-driven latency/rate vectors, hand-written corner
// sequences and a randomized run against an event-time reference model.
module tb_steer_quad_encoder;

    localparam int CH = 2;
    localparam int DW = 16;

    typedef struct {
        int mx;
        int mn;
        int acc;
        int ch;
        int rgt;
        int lat;
        int gap;
        int ph;
    } vec_t;

    logic CLK   = 1'b0;
    logic reset = 1'b1;

    steer_quad_encoder_if #(.CHANNELS(CH), .DIV_W(DW)) bus ();

    steer_quad_encoder #(.CHANNELS(CH), .DIV_W(DW), .ACCEL_SHIFT(3)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    int r_max, r_min, r_acc;
    logic [CH-1:0] m_s1l, m_s1r, m_s2l, m_s2r;
    int m_prev[CH], m_next[CH], m_per[CH], m_pos[CH], m_t;
    bit m_stp[CH];
    logic [1:0] enc[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_window(input int mx, input int mn, input int acc);
        r_max = mx;
        r_min = mn;
        r_acc = acc;
        bus.clkdiv_max = DW'(mx);
        bus.clkdiv_min = DW'(mn);
        bus.accel_en   = acc[0];
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        bus.left  = '0;
        bus.right = '0;
        repeat (2) @(negedge CLK);
        check("reset_steer", int'(bus.steer), 0);
        check("reset_step", int'(bus.step), 0);
        reset = 1'b0;
    endtask

    // Counts falling edges until step[ch] is seen high, bounded by limit
    task automatic wait_step(input int ch, input int limit, output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!bus.step[ch] && n < limit);
        if (!bus.step[ch]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL step_timeout: ch%0d got no step, expected one within %0d cycles", ch, limit);
        end
    endtask

    function automatic int emax();
        return r_max == 0 ? 1 : r_max;
    endfunction

    function automatic int emin();
        int lo = r_min == 0 ? 1 : r_min;
        return lo > emax() ? emax() : lo;
    endfunction

    function automatic int decode(input logic l, input logic r);
        return (r && !l) ? 1 : (l && !r) ? -1 : 0;
    endfunction

    task automatic model_reset();
        m_t = 0;
        m_s1l = '0; m_s1r = '0; m_s2l = '0; m_s2r = '0;
        for (int c = 0; c < CH; c++) begin
            m_prev[c] = 0; m_next[c] = 0; m_per[c] = 0; m_pos[c] = 0; m_stp[c] = 0;
        end
    endtask

    // Event-time model: a run starting at cycle t steps at t+emax, then each
    // later step is scheduled one (ramped) period after the previous one
    task automatic model_edge();
        int c_now, dstep, p;
        m_t++;
        m_s2l = m_s1l; m_s2r = m_s1r;
        m_s1l = bus.left; m_s1r = bus.right;
        for (int c = 0; c < CH; c++) begin
            if (m_stp[c]) m_pos[c] = (m_pos[c] + m_prev[c] + 4) % 4;
            c_now = decode(m_s2l[c], m_s2r[c]);
            m_stp[c] = 0;
            if (c_now != 0 && c_now != m_prev[c]) begin
                m_per[c]  = emax();
                m_next[c] = m_t + emax();
            end else if (c_now != 0 && m_t == m_next[c]) begin
                m_stp[c] = 1;
                p = m_per[c];
                dstep = p / 8 < 1 ? 1 : p / 8;
                m_per[c]  = r_acc != 0 ? ((p - dstep) < emin() ? emin() : p - dstep) : emax();
                m_next[c] = m_t + m_per[c];
            end
            m_prev[c] = c_now;
        end
    endtask

    initial begin
        vec_t vecs[6];
        logic [1:0] lseq[4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        int ramp_exp[13] = '{56, 49, 43, 38, 34, 30, 27, 24, 21, 19, 17, 16, 16};
        int n, hits, exp_steer, exp_step;

        vecs[0] = '{mx: 8,  mn: 1,  acc: 0, ch: 0, rgt: 1, lat: 10, gap: 8,  ph: 2};
        vecs[1] = '{mx: 64, mn: 16, acc: 1, ch: 1, rgt: 0, lat: 66, gap: 56, ph: 1};
        vecs[2] = '{mx: 0,  mn: 5,  acc: 0, ch: 0, rgt: 1, lat: 3,  gap: 1,  ph: 2};
        vecs[3] = '{mx: 4,  mn: 0,  acc: 1, ch: 1, rgt: 1, lat: 6,  gap: 3,  ph: 2};
        vecs[4] = '{mx: 3,  mn: 9,  acc: 1, ch: 0, rgt: 0, lat: 5,  gap: 3,  ph: 1};
        vecs[5] = '{mx: 1,  mn: 1,  acc: 1, ch: 1, rgt: 0, lat: 3,  gap: 1,  ph: 1};

        set_window(8, 1, 0);
        bus.left  = '0;
        bus.right = '0;

        for (int i = 0; i < 6; i++) begin
            set_window(vecs[i].mx, vecs[i].mn, vecs[i].acc);
            do_reset();
            bus.right[vecs[i].ch] = vecs[i].rgt[0];
            bus.left[vecs[i].ch]  = !vecs[i].rgt[0];
            wait_step(vecs[i].ch, 200, n);
            check($sformatf("vec%0d_latency", i), n, vecs[i].lat);
            wait_step(vecs[i].ch, 200, n);
            check($sformatf("vec%0d_gap", i), n, vecs[i].gap);
            check($sformatf("vec%0d_phase", i), int'(bus.steer[2*vecs[i].ch+:2]), vecs[i].ph);
        end

        // Acceleration ramp on channel 1 down to the floor, left phase order
        set_window(64, 16, 1);
        do_reset();
        bus.left[1] = 1'b1;
        wait_step(1, 200, n);
        check("ramp_first", n, 66);
        for (int i = 0; i < 13; i++) begin
            wait_step(1, 200, n);
            check($sformatf("ramp_gap%0d", i), n, ramp_exp[i]);
            check($sformatf("ramp_phase%0d", i), int'(bus.steer[3:2]), int'(lseq[i % 4]));
        end

        // Direction reversal right after a step
        set_window(8, 1, 1);
        do_reset();
        bus.right[0] = 1'b1;
        wait_step(0, 200, n);
        check("rev_first", n, 10);
        wait_step(0, 200, n);
        check("rev_gap", n, 7);
        bus.right[0] = 1'b0;
        bus.left[0]  = 1'b1;
        wait_step(0, 200, n);
        check("rev_latency", n, 10);
        check("rev_phase_at_step", int'(bus.steer[1:0]), 3);
        @(negedge CLK);
        check("rev_phase_back", int'(bus.steer[1:0]), 2);

        // Both directions held means no command
        set_window(8, 1, 0);
        do_reset();
        bus.left[0]  = 1'b1;
        bus.right[0] = 1'b1;
        hits = 0;
        repeat (30) begin
            @(negedge CLK);
            if (bus.step[0]) hits++;
        end
        check("both_no_step", hits, 0);
        check("both_steer_held", int'(bus.steer[1:0]), 0);
        bus.left[0] = 1'b0;
        wait_step(0, 200, n);
        check("both_release_latency", n, 10);
        @(negedge CLK);
        check("both_release_phase", int'(bus.steer[1:0]), 2);

        // Reset mid-hold on two channels
        set_window(8, 1, 0);
        do_reset();
        bus.right[0] = 1'b1;
        bus.left[1]  = 1'b1;
        wait_step(0, 200, n);
        check("mid_first", n, 10);
        repeat (4) @(posedge CLK);
        #1 reset = 1'b1;
        #1;
        check("mid_reset_steer", int'(bus.steer), 0);
        check("mid_reset_step", int'(bus.step), 0);
        @(negedge CLK);
        reset = 1'b0;
        wait_step(0, 200, n);
        check("mid_restart_latency", n, 10);
        check("mid_restart_ch1", int'(bus.step[1]), 1);

        // Randomized run against the reference model
        for (int seg = 0; seg < 4; seg++) begin
            set_window($urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 1));
            do_reset();
            model_reset();
            for (int cyc = 0; cyc < 1500; cyc++) begin
                for (int c = 0; c < CH; c++) begin
                    if ($urandom_range(0, 15) == 0) begin
                        n = $urandom_range(0, 3);
                        bus.left[c]  = n[0];
                        bus.right[c] = n[1];
                    end
                end
                @(posedge CLK);
                model_edge();
                @(negedge CLK);
                exp_steer = 0;
                exp_step  = 0;
                for (int c = 0; c < CH; c++) begin
                    exp_steer |= int'(enc[m_pos[c]]) << (2 * c);
                    exp_step  |= int'(m_stp[c]) << c;
                end
                check("rand_step", int'(bus.step), exp_step);
                check("rand_steer", int'(bus.steer), exp_steer);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
